// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and constants for the multicycle MIPS controller
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_HALT    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/aludec.sv
// rtl/aludec.sv - ALU operation decoder from ALUOp and R-type funct field
module aludec
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   input  logic [1:0] aluop,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         default: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the shared-memory multicycle MIPS datapath
module multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter bit USE_MEM_READY   = 1'b1,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemToReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic [2:0] alucontrol,
   output logic       halted
);

   state_t     state;
   state_t     state_next;
   state_t     dec_state;
   logic       rdy;
   logic       pcwrite;
   logic       branch;
   logic [1:0] aluop;

   assign rdy = USE_MEM_READY ? mem_ready : 1'b1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:   state_next = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_RTYPEEX;
               OP_BEQ:       state_next = S_BEQEX;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JEX;
               default:      state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
            endcase
         end
         S_MEMADR:  state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_next = rdy ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_next = S_FETCH;
         S_MEMWR:   state_next = rdy ? S_FETCH : S_MEMWR;
         S_RTYPEEX: state_next = S_RTYPEWB;
         S_RTYPEWB: state_next = S_FETCH;
         S_BEQEX:   state_next = S_FETCH;
         S_ADDIEX:  state_next = S_ADDIWB;
         S_ADDIWB:  state_next = S_FETCH;
         S_JEX:     state_next = S_FETCH;
         S_HALT:    state_next = S_HALT;
         default:   state_next = S_FETCH;
      endcase
   end

   // While in reset the datapath sees FETCH decode, with enables stripped below.
   assign dec_state = reset_n ? state : S_FETCH;

   always_comb begin
      mem_req  = 1'b0;
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemToReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      PCSrc    = 2'b00;
      halted   = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      aluop    = ALUOP_ADD;
      case (dec_state)
         S_FETCH: begin
            mem_req = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = rdy;
            pcwrite = rdy;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_RTYPEEX: begin
            ALUSrcA = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BEQEX: begin
            ALUSrcA = 1'b1;
            aluop   = ALUOP_SUB;
            PCSrc   = 2'b01;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JEX: begin
            PCSrc   = 2'b10;
            pcwrite = 1'b1;
         end
         S_HALT:   halted = 1'b1;
         default: ;
      endcase
      if (!reset_n) begin
         mem_req  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         pcwrite  = 1'b0;
         branch   = 1'b0;
      end
   end

   assign PCEn = pcwrite | (branch & zero);

   aludec u_aludec (
      .funct      (funct),
      .aluop      (aluop),
      .alucontrol (alucontrol)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed scoreboard bench for multicycle_controller
module tb_multicycle_controller;

   localparam int T_RST = 0, T_FETCH = 1, T_DECODE = 2, T_MEMADR = 3, T_MEMRD = 4,
                  T_MEMWB = 5, T_MEMWR = 6, T_RTYPEEX = 7, T_RTYPEWB = 8, T_BEQEX = 9,
                  T_ADDIEX = 10, T_ADDIWB = 11, T_JEX = 12, T_HALT = 13;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic       PCEn;
   logic [2:0] alucontrol;
   logic       halted;

   int ntests = 0;
   int nfail  = 0;

   logic [16:0] exp_q[$];
   string       tag_q[$];

   multicycle_controller #(.USE_MEM_READY(1'b1), .HALT_ON_ILLEGAL(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .IorD       (IorD),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .MemToReg   (MemToReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .PCSrc      (PCSrc),
      .PCEn       (PCEn),
      .alucontrol (alucontrol),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   // Expected output vector for a symbolic state, taken from the control table.
   // Layout: mem_req IorD MemWrite IRWrite RegDst MemToReg RegWrite ALUSrcA ALUSrcB PCSrc PCEn alucontrol halted
   function automatic logic [16:0] ev(input int st, input logic z, input logic rdy, input logic [2:0] fa);
      logic mr, iod, mw, irw, rd, m2r, rw, sa, pce, hl;
      logic [1:0] sb, ps;
      logic [2:0] ac;
      {mr, iod, mw, irw, rd, m2r, rw, sa, pce, hl} = '0;
      sb = 2'b00; ps = 2'b00; ac = 3'b010;
      case (st)
         T_RST:     sb = 2'b01;
         T_FETCH:   begin mr = 1; sb = 2'b01; irw = rdy; pce = rdy; end
         T_DECODE:  sb = 2'b11;
         T_MEMADR:  begin sa = 1; sb = 2'b10; end
         T_MEMRD:   begin mr = 1; iod = 1; end
         T_MEMWB:   begin m2r = 1; rw = 1; end
         T_MEMWR:   begin mr = 1; iod = 1; mw = 1; end
         T_RTYPEEX: begin sa = 1; ac = fa; end
         T_RTYPEWB: begin rd = 1; rw = 1; end
         T_BEQEX:   begin sa = 1; ps = 2'b01; pce = z; ac = 3'b110; end
         T_ADDIEX:  begin sa = 1; sb = 2'b10; end
         T_ADDIWB:  rw = 1;
         T_JEX:     begin ps = 2'b10; pce = 1; end
         T_HALT:    hl = 1;
         default: ;
      endcase
      return {mr, iod, mw, irw, rd, m2r, rw, sa, sb, ps, pce, ac, hl};
   endfunction

   // Drive one cycle, push its expectation, then pop and compare mid-cycle.
   task automatic step(input string tag, input int st, input logic rn, input logic rdy,
                       input logic z, input logic [2:0] fa);
      logic [16:0] obs, exp_v;
      string       t;
      reset_n   = rn;
      mem_ready = rdy;
      zero      = z;
      exp_q.push_back(ev(st, z, rdy, fa));
      tag_q.push_back(tag);
      @(negedge clk);
      obs = {mem_req, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA,
             ALUSrcB, PCSrc, PCEn, alucontrol, halted};
      exp_v = exp_q.pop_front();
      t     = tag_q.pop_front();
      ntests++;
      assert (obs === exp_v) else begin
         nfail++;
         $error("FAIL %s: observed %b expected %b", t, obs, exp_v);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      funct  = fn;
   endtask

   initial begin
      reset_n = 1'b0; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      step("reset0", T_RST, 0, 1, 0, 3'b010);
      step("reset1", T_RST, 0, 1, 0, 3'b010);

      // reset asserted while in DECODE
      instr(6'b000000, 6'b100000);
      step("rd_fetch", T_FETCH, 1, 1, 0, 3'b010);
      step("rd_rst_a", T_RST, 0, 1, 0, 3'b010);
      step("rd_rst_b", T_RST, 0, 1, 0, 3'b010);

      // add
      step("add_fetch", T_FETCH, 1, 1, 0, 3'b010);
      step("add_dec", T_DECODE, 1, 1, 0, 3'b010);
      step("add_ex", T_RTYPEEX, 1, 1, 0, 3'b010);
      step("add_wb", T_RTYPEWB, 1, 1, 0, 3'b010);

      // sub, mem_ready low outside wait states is ignored
      instr(6'b000000, 6'b100010);
      step("sub_fetch", T_FETCH, 1, 1, 0, 3'b010);
      step("sub_dec", T_DECODE, 1, 0, 0, 3'b010);
      step("sub_ex", T_RTYPEEX, 1, 0, 0, 3'b110);
      step("sub_wb", T_RTYPEWB, 1, 0, 0, 3'b010);

      // lw with two stall cycles in MEMRD
      instr(6'b100011, 6'b000000);
      step("lw_fetch", T_FETCH, 1, 1, 0, 3'b010);
      step("lw_dec", T_DECODE, 1, 1, 0, 3'b010);
      step("lw_adr", T_MEMADR, 1, 1, 0, 3'b010);
      step("lw_rd0", T_MEMRD, 1, 0, 0, 3'b010);
      step("lw_rd1", T_MEMRD, 1, 0, 0, 3'b010);
      step("lw_rd2", T_MEMRD, 1, 1, 0, 3'b010);
      step("lw_wb", T_MEMWB, 1, 1, 0, 3'b010);

      // beq taken then not taken
      instr(6'b000100, 6'b000000);
      step("beq1_fetch", T_FETCH, 1, 1, 1, 3'b010);
      step("beq1_dec", T_DECODE, 1, 1, 1, 3'b010);
      step("beq1_ex", T_BEQEX, 1, 1, 1, 3'b010);
      step("beq0_fetch", T_FETCH, 1, 1, 0, 3'b010);
      step("beq0_dec", T_DECODE, 1, 1, 0, 3'b010);
      step("beq0_ex", T_BEQEX, 1, 1, 0, 3'b010);

      // addi with a FETCH stall
      instr(6'b001000, 6'b000000);
      step("addi_fetch0", T_FETCH, 1, 0, 0, 3'b010);
      step("addi_fetch1", T_FETCH, 1, 1, 0, 3'b010);
      step("addi_dec", T_DECODE, 1, 1, 0, 3'b010);
      step("addi_ex", T_ADDIEX, 1, 1, 0, 3'b010);
      step("addi_wb", T_ADDIWB, 1, 1, 0, 3'b010);

      // j
      instr(6'b000010, 6'b000000);
      step("j_fetch", T_FETCH, 1, 1, 0, 3'b010);
      step("j_dec", T_DECODE, 1, 1, 0, 3'b010);
      step("j_ex", T_JEX, 1, 1, 0, 3'b010);

      // sw interrupted by reset in the second MEMWR cycle
      instr(6'b101011, 6'b000000);
      step("sw_fetch", T_FETCH, 1, 1, 0, 3'b010);
      step("sw_dec", T_DECODE, 1, 1, 0, 3'b010);
      step("sw_adr", T_MEMADR, 1, 1, 0, 3'b010);
      step("sw_wr0", T_MEMWR, 1, 0, 0, 3'b010);
      step("sw_wr_rst", T_RST, 0, 0, 0, 3'b010);
      step("sw_after_rst", T_FETCH, 1, 1, 0, 3'b010);
      step("sw2_dec", T_DECODE, 1, 1, 0, 3'b010);
      step("sw2_adr", T_MEMADR, 1, 1, 0, 3'b010);
      step("sw2_wr", T_MEMWR, 1, 1, 0, 3'b010);
      step("sw2_next", T_FETCH, 1, 1, 0, 3'b010);

      // illegal opcode halts until reset
      instr(6'b111111, 6'b000000);
      step("ill_dec", T_DECODE, 1, 1, 0, 3'b010);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) instr(6'b100011, 6'b000000);
         step($sformatf("halt%0d", i), T_HALT, 1, logic'(i % 2), logic'((i / 3) % 2), 3'b010);
      end
      step("halt_rst", T_RST, 0, 1, 0, 3'b010);
      instr(6'b000010, 6'b000000);
      step("post_halt_fetch", T_FETCH, 1, 1, 0, 3'b010);
      step("post_halt_dec", T_DECODE, 1, 1, 0, 3'b010);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
